// File: rtl/present_inv_sbox_serial.sv
// Iterative PRESENT inverse S-box layer: NPC nibbles per cycle over a 64-bit state.
// Latency: STEPS = 16/NPC clock edges from accept to out_valid.
// Backpressure: one block in flight. in_ready is low outside IDLE. DONE holds until out_ready.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     accept side; in_data nibble k = in_data[4k+3:4k]
//   out_valid/out_ready   result side; out_data is driven straight from the work register
//   err                   sticky self-check failure (macro PRESENT_INV_SBOX_SELFCHECK_EN), else 0
module present_inv_sbox_serial #(
   parameter int NPC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        err
);

   localparam int STEPS = 16 / NPC;
   localparam int CW    = $clog2(STEPS) + 1;
   localparam int GW    = 4 * NPC;

   generate
      if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
         $error("present_inv_sbox_serial: NPC must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state, state_nxt;
   logic [63:0]    work;
   logic [CW-1:0]  cnt;
   logic [GW-1:0]  grp_in, grp_out;
   logic [63:0]    work_sub;
   logic           accept, last;

   assign accept   = (state == IDLE) && in_valid;
   assign last     = (cnt == CW'(STEPS - 1));
   assign out_data = work;

   // Pick the nibble group addressed by cnt (LSB group first).
   always_comb begin
      grp_in = '0;
      for (int g = 0; g < STEPS; g++) begin
         if (cnt == CW'(g)) grp_in = work[g*GW +: GW];
      end
   end

   // NPC copies of the shared inverse S-box.
   generate
      for (genvar i = 0; i < NPC; i++) begin : g_sbox
         assign grp_out[4*i +: 4] = inv_sbox(grp_in[4*i +: 4]);
      end
   endgenerate

   // Work with the current group replaced; everything else passes through.
   always_comb begin
      work_sub = work;
      for (int g = 0; g < STEPS; g++) begin
         if (cnt == CW'(g)) work_sub[g*GW +: GW] = grp_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work <= '0;
         cnt  <= '0;
      end else if (accept) begin
         work <= in_data;
         cnt  <= '0;
      end else if (state == BUSY) begin
         work <= work_sub;
         cnt  <= cnt + 1'b1;
      end
   end

`ifdef PRESENT_INV_SBOX_SELFCHECK_EN
   function automatic logic [3:0] fwd_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   logic [63:0] in_copy;
   logic [63:0] fwd_all;
   logic        err_q;

   // Re-encrypt the value being written on the DONE-entry edge so err lines up with out_valid.
   always_comb begin
      fwd_all = '0;
      for (int k = 0; k < 16; k++) fwd_all[4*k +: 4] = fwd_sbox(work_sub[4*k +: 4]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_copy <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) in_copy <= in_data;
         if (state == BUSY && last && fwd_all != in_copy) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_present_inv_sbox_serial.sv
// Directed bench for present_inv_sbox_serial: five instances (NPC 4,1,2,8,16) share stimulus.
// Latency: each instance's latency is measured independently against 16/NPC.
// Backpressure: exercises out_ready held low, mid-flight reset and back-to-back throughput.
module tb_present_inv_sbox_serial;

   function automatic int npc_of(input int g);
      case (g)
         0: return 4;
         1: return 1;
         2: return 2;
         3: return 8;
         default: return 16;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] in_data;
   logic [4:0]  ir, ov, er;
   logic [63:0] od [5];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 5; g++) begin : g_dut
         present_inv_sbox_serial #(.NPC(npc_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .err       (er[g])
         );
      end
   endgenerate

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int g, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s npc%0d: observed %h expected %h", tag, npc_of(g), got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      for (int g = 0; g < 5; g++) begin
         chk({tag, " in_ready"}, g, 64'(ir[g]), 64'd1);
         chk({tag, " out_valid"}, g, 64'(ov[g]), 64'd0);
      end
   endtask

   // Accept one block, measure latency per instance, hold in DONE, then release.
   task automatic run_block(input logic [63:0] d, input logic [63:0] exp);
      int lat [5];
      chk_idle("pre-accept");
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = ~d;
      for (int g = 0; g < 5; g++) lat[g] = 0;
      for (int c = 1; c <= 17; c++) begin
         tick();
         for (int g = 0; g < 5; g++) if (ov[g] && lat[g] == 0) lat[g] = c;
      end
      for (int g = 0; g < 5; g++) begin
         chk("latency", g, 64'(lat[g]), 64'(16 / npc_of(g)));
         chk("out_data", g, od[g], exp);
         chk("err", g, 64'(er[g]), 64'd0);
         chk("in_ready in DONE", g, 64'(ir[g]), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle("release");
   endtask

   initial begin
      int last_acc [5];
      int nacc [5];
      int p;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      tick();
      tick();
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         chk("reset out_data", g, od[g], 64'h0);
         chk("reset err", g, 64'(er[g]), 64'd0);
      end
      chk_idle("reset");

      run_block(64'h0000000000000000, 64'h5555555555555555);
      run_block(64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);
      run_block(64'hC56B90AD3EF84712, 64'h0123456789ABCDEF);

      // Long hold in DONE with stray in_valid pulses.
      in_data  = 64'hFFFFFFFFFFFFFFFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (17) tick();
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         in_data  = 64'h0123456789ABCDEF;
         tick();
         for (int g = 0; g < 5; g++) begin
            chk("hold out_valid", g, 64'(ov[g]), 64'd1);
            chk("hold out_data", g, od[g], 64'hAAAAAAAAAAAAAAAA);
            chk("hold in_ready", g, 64'(ir[g]), 64'd0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle("hold release");

      // Reset during the second BUSY cycle discards the block.
      in_data  = 64'h1111111111111111;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         chk("midrst out_data", g, od[g], 64'h0);
         chk("midrst err", g, 64'(er[g]), 64'd0);
      end
      chk_idle("midrst");
      run_block(64'h0123456789ABCDEF, 64'h5EF8C12DB463079A);

      // Back-to-back with in_valid and out_ready held high.
      for (int g = 0; g < 5; g++) begin
         last_acc[g] = -1;
         nacc[g]     = 0;
      end
      in_data   = 64'h0123456789ABCDEF;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         for (int g = 0; g < 5; g++) begin
            if (ir[g]) begin
               if (last_acc[g] >= 0)
                  chk("b2b period", g, 64'(c - last_acc[g]), 64'(16 / npc_of(g) + 2));
               last_acc[g] = c;
               nacc[g]++;
            end
            if (ov[g]) chk("b2b out_data", g, od[g], 64'h5EF8C12DB463079A);
         end
         tick();
      end
      in_valid = 1'b0;
      for (int g = 0; g < 5; g++) begin
         p = 16 / npc_of(g) + 2;
         chk("b2b accepts", g, 64'(nacc[g]), 64'((60 + p - 1) / p));
      end
      repeat (20) tick();
      out_ready = 1'b0;
      chk_idle("drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
